// File: rtl/hi_lo_ctrl.sv
// HI/LO register pair plus issue/commit control for the multi-cycle multiply/divide unit.
// Holds the unit's command stable while BUSY and interlocks HI/LO instructions until commit.
module hi_lo_ctrl #(
   parameter int N       = 32,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         op_valid,
   input  logic [2:0]   op,
   input  logic         op_sign,
   input  logic [N-1:0] rs_val,
   input  logic [N-1:0] rt_val,
   output logic         stall,
   output logic [N-1:0] rd_val,
   output logic         rd_valid,
   output logic         err,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         du_mul,
   output logic         du_div,
   output logic         du_add,
   output logic         du_sub,
   output logic         du_sign,
   output logic [N-1:0] du_a,
   output logic [N-1:0] du_b,
   output logic [N-1:0] du_hi_in,
   output logic [N-1:0] du_lo_in,
   output logic         du_clear,
   output logic         du_hold_result,
   input  logic [N-1:0] du_hi_out,
   input  logic [N-1:0] du_lo_out,
   input  logic         du_write_hi_lo,
   input  logic         du_waiting_result
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int              CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   localparam logic [2:0] OP_MULT = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_MADD = 3'd2;
   localparam logic [2:0] OP_MSUB = 3'd3;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;
   localparam logic [2:0] OP_MFHI = 3'd6;
   localparam logic [2:0] OP_MFLO = 3'd7;

   state_t          state_r;
   state_t          state_s;
   logic [CW-1:0]   cnt_r;
   logic [N-1:0]    hi_r;
   logic [N-1:0]    lo_r;
   logic            accept_s;
   logic            wr_hi_s;
   logic            wr_lo_s;
   logic            commit_s;
   logic            timeout_s;
   logic            unused_s;

   // The busy flag is only informational; commit is decided by the write strobe alone.
   assign unused_s       = du_waiting_result;

   assign hi             = hi_r;
   assign lo             = lo_r;
   assign du_hi_in       = hi_r;
   assign du_lo_in       = lo_r;
   assign du_hold_result = 1'b0;
   assign err            = timeout_s;
   assign du_clear       = flush | timeout_s;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: any abort or commit returns to IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = BUSY;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (flush || commit_s || timeout_s) begin
               state_s = IDLE;
            end else begin
               state_s = BUSY;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Output decode: interlock, MFHI/MFLO read port and per-cycle strobes.
   always_comb begin
      stall     = 1'b0;
      rd_valid  = 1'b0;
      rd_val    = {N{1'b0}};
      accept_s  = 1'b0;
      wr_hi_s   = 1'b0;
      wr_lo_s   = 1'b0;
      commit_s  = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (op_valid && !flush) begin
               case (op)
                  OP_MULT, OP_DIV, OP_MADD, OP_MSUB: accept_s = 1'b1;
                  OP_MTHI: wr_hi_s = 1'b1;
                  OP_MTLO: wr_lo_s = 1'b1;
                  OP_MFHI: begin
                     rd_valid = 1'b1;
                     rd_val   = hi_r;
                  end
                  OP_MFLO: begin
                     rd_valid = 1'b1;
                     rd_val   = lo_r;
                  end
                  default: accept_s = 1'b0;
               endcase
            end else begin
               accept_s = 1'b0;
            end
         end
         BUSY: begin
            stall = op_valid && !flush;
            if (flush) begin
               commit_s = 1'b0;
            end else if (du_write_hi_lo) begin
               commit_s = 1'b1;
            end else if (cnt_r == CNT_LAST) begin
               timeout_s = 1'b1;
            end else begin
               commit_s = 1'b0;
            end
         end
         default: stall = 1'b0;
      endcase
   end

   // Command and operand registers driven to the unit; held for the whole computation.
   always_ff @(posedge clk) begin
      if (reset) begin
         du_mul  <= 1'b0;
         du_div  <= 1'b0;
         du_add  <= 1'b0;
         du_sub  <= 1'b0;
         du_sign <= 1'b0;
         du_a    <= {N{1'b0}};
         du_b    <= {N{1'b0}};
      end else if (accept_s) begin
         du_mul  <= (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
         du_div  <= (op == OP_DIV);
         du_add  <= (op == OP_MADD);
         du_sub  <= (op == OP_MSUB);
         du_sign <= op_sign;
         du_a    <= rs_val;
         du_b    <= rt_val;
      end else if (flush || commit_s || timeout_s) begin
         du_mul  <= 1'b0;
         du_div  <= 1'b0;
         du_add  <= 1'b0;
         du_sub  <= 1'b0;
         du_sign <= 1'b0;
      end else begin
         du_mul  <= du_mul;
         du_div  <= du_div;
      end
   end

   // Watchdog counter: cleared on issue, counts every BUSY cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
         cnt_r <= {CW{1'b0}};
      end else if (state_r == BUSY) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Architectural HI/LO: unit commit or MTHI/MTLO (never both in one cycle).
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r <= {N{1'b0}};
         lo_r <= {N{1'b0}};
      end else if (commit_s) begin
         hi_r <= du_hi_out;
         lo_r <= du_lo_out;
      end else begin
         if (wr_hi_s) begin
            hi_r <= rs_val;
         end else begin
            hi_r <= hi_r;
         end
         if (wr_lo_s) begin
            lo_r <= rs_val;
         end else begin
            lo_r <= lo_r;
         end
      end
   end

endmodule

// File: tb/tb_hi_lo_ctrl.sv
// Directed self-checking bench for hi_lo_ctrl; the unit is modelled by hand-driven strobes.
module tb_hi_lo_ctrl;

   localparam int N  = 32;
   localparam int TO = 64;

   logic         clk = 1'b0;
   logic         reset, flush, op_valid, op_sign;
   logic [2:0]   op;
   logic [N-1:0] rs_val, rt_val;
   logic         stall, rd_valid, err;
   logic [N-1:0] rd_val, hi, lo;
   logic         du_mul, du_div, du_add, du_sub, du_sign;
   logic [N-1:0] du_a, du_b, du_hi_in, du_lo_in;
   logic         du_clear, du_hold_result;
   logic [N-1:0] du_hi_out, du_lo_out;
   logic         du_write_hi_lo, du_waiting_result;

   int n_cmp = 0;
   int n_bad = 0;

   hi_lo_ctrl #(.N(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op(op),
      .op_sign(op_sign), .rs_val(rs_val), .rt_val(rt_val), .stall(stall),
      .rd_val(rd_val), .rd_valid(rd_valid), .err(err), .hi(hi), .lo(lo),
      .du_mul(du_mul), .du_div(du_div), .du_add(du_add), .du_sub(du_sub),
      .du_sign(du_sign), .du_a(du_a), .du_b(du_b), .du_hi_in(du_hi_in),
      .du_lo_in(du_lo_in), .du_clear(du_clear), .du_hold_result(du_hold_result),
      .du_hi_out(du_hi_out), .du_lo_out(du_lo_out), .du_write_hi_lo(du_write_hi_lo),
      .du_waiting_result(du_waiting_result)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are then set and checked at +2.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [2:0] o, input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
      op_valid = 1'b1; op = o; op_sign = s; rs_val = a; rt_val = b;
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0; op_sign = 1'b0;
      rs_val = 32'd0; rt_val = 32'd0; du_hi_out = 32'd0; du_lo_out = 32'd0;
      du_write_hi_lo = 1'b0; du_waiting_result = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #2;
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %0h want 0", hi); end
      n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %0h want 0", lo); end
      n_cmp++; if ({stall, rd_valid, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {stall, rd_valid, err}); end
      n_cmp++; if ({du_mul, du_div, du_add, du_sub, du_sign} !== 5'b0) begin n_bad++; $display("FAIL reset_cmd: got %b want 00000", {du_mul, du_div, du_add, du_sub, du_sign}); end
      n_cmp++; if ({du_a, du_b} !== 64'd0) begin n_bad++; $display("FAIL reset_ops: got %0h/%0h want 0/0", du_a, du_b); end
      n_cmp++; if ({du_hold_result, du_clear} !== 2'b00) begin n_bad++; $display("FAIL reset_du_ctl: got %b want 00", {du_hold_result, du_clear}); end
   endtask

   task automatic test_mult_mflo();
      int bad_stall;
      tick();
      present(3'd0, 1'b0, 32'd7, 32'd6);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mult_accept_stall: got %b want 0", stall); end
      tick();
      present(3'd7, 1'b0, 32'd0, 32'd0);
      n_cmp++; if ({du_mul, du_div, du_add, du_sub, du_sign} !== 5'b10000) begin n_bad++; $display("FAIL mult_cmd: got %b want 10000", {du_mul, du_div, du_add, du_sub, du_sign}); end
      n_cmp++; if (du_a !== 32'd7 || du_b !== 32'd6) begin n_bad++; $display("FAIL mult_ops: got %0d/%0d want 7/6", du_a, du_b); end
      n_cmp++; if (stall !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL mflo_stalled: got stall=%b rd_valid=%b want 1/0", stall, rd_valid); end
      bad_stall = 0;
      for (int i = 0; i < 32; i++) begin
         tick(); #2;
         if (stall !== 1'b1 || du_mul !== 1'b1 || du_a !== 32'd7) bad_stall++;
      end
      n_cmp++; if (bad_stall !== 0) begin n_bad++; $display("FAIL mult_hold: got %0d bad cycles want 0", bad_stall); end
      tick();
      du_write_hi_lo = 1'b1; du_hi_out = 32'd0; du_lo_out = 32'd42;
      #2;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL commit_cycle_stall: got %b want 1", stall); end
      tick();
      du_write_hi_lo = 1'b0; du_lo_out = 32'd0;
      #2;
      n_cmp++; if (hi !== 32'd0 || lo !== 32'd42) begin n_bad++; $display("FAIL mult_commit: got %0d/%0d want 0/42", hi, lo); end
      n_cmp++; if (du_mul !== 1'b0) begin n_bad++; $display("FAIL mult_cmd_clear: got %b want 0", du_mul); end
      n_cmp++; if (stall !== 1'b0 || rd_valid !== 1'b1 || rd_val !== 32'd42) begin n_bad++; $display("FAIL mflo_read: got stall=%b valid=%b val=%0d want 0/1/42", stall, rd_valid, rd_val); end
      op_valid = 1'b0;
   endtask

   task automatic test_mthi_mfhi();
      tick();
      present(3'd4, 1'b0, 32'h0000DEAD, 32'd0);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mthi_stall: got %b want 0", stall); end
      tick();
      present(3'd6, 1'b0, 32'd0, 32'd0);
      n_cmp++; if (stall !== 1'b0 || rd_valid !== 1'b1 || rd_val !== 32'h0000DEAD) begin n_bad++; $display("FAIL mfhi_read: got stall=%b valid=%b val=%0h want 0/1/dead", stall, rd_valid, rd_val); end
      n_cmp++; if (lo !== 32'd42) begin n_bad++; $display("FAIL mthi_lo_kept: got %0d want 42", lo); end
      op_valid = 1'b0;
   endtask

   task automatic test_madd();
      int bad_hold;
      tick(); present(3'd5, 1'b0, 32'd5, 32'd0);
      tick(); present(3'd4, 1'b0, 32'd0, 32'd0);
      tick(); present(3'd2, 1'b1, 32'd6, 32'd7);
      tick(); op_valid = 1'b0; #2;
      n_cmp++; if ({du_mul, du_div, du_add, du_sub, du_sign} !== 5'b10101) begin n_bad++; $display("FAIL madd_cmd: got %b want 10101", {du_mul, du_div, du_add, du_sub, du_sign}); end
      n_cmp++; if (du_lo_in !== 32'd5 || du_hi_in !== 32'd0) begin n_bad++; $display("FAIL madd_acc_in: got %0d/%0d want 0/5", du_hi_in, du_lo_in); end
      bad_hold = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); #2;
         if ({du_mul, du_add, du_sign} !== 3'b111 || du_lo_in !== 32'd5 || du_hi_in !== 32'd0 || du_a !== 32'd6 || du_b !== 32'd7) bad_hold++;
      end
      n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL madd_hold: got %0d bad cycles want 0", bad_hold); end
      tick();
      du_write_hi_lo = 1'b1; du_hi_out = 32'd0; du_lo_out = 32'd47;
      tick();
      du_write_hi_lo = 1'b0; du_lo_out = 32'd0;
      #2;
      n_cmp++; if (lo !== 32'd47 || hi !== 32'd0) begin n_bad++; $display("FAIL madd_commit: got %0d/%0d want 0/47", hi, lo); end
      n_cmp++; if ({du_mul, du_add, du_sign} !== 3'b000) begin n_bad++; $display("FAIL madd_cmd_clear: got %b want 000", {du_mul, du_add, du_sign}); end
   endtask

   task automatic test_flush();
      tick(); present(3'd1, 1'b1, 32'd100, 32'd7);
      tick(); op_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      flush = 1'b1; #2;
      n_cmp++; if (du_clear !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL flush_clear: got clear=%b err=%b want 1/0", du_clear, err); end
      tick(); flush = 1'b0;
      present(3'd6, 1'b0, 32'd0, 32'd0);
      n_cmp++; if (du_clear !== 1'b0 || du_div !== 1'b0) begin n_bad++; $display("FAIL flush_after: got clear=%b div=%b want 0/0", du_clear, du_div); end
      n_cmp++; if (stall !== 1'b0 || rd_valid !== 1'b1 || rd_val !== 32'd0) begin n_bad++; $display("FAIL flush_idle_mfhi: got stall=%b valid=%b val=%0d want 0/1/0", stall, rd_valid, rd_val); end
      n_cmp++; if (lo !== 32'd47) begin n_bad++; $display("FAIL flush_lo_kept: got %0d want 47", lo); end
      tick(); present(3'd1, 1'b0, 32'd9, 32'd3);
      tick(); op_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      flush = 1'b1; du_write_hi_lo = 1'b1; du_hi_out = 32'h1111; du_lo_out = 32'h2222;
      tick();
      flush = 1'b0; du_write_hi_lo = 1'b0;
      #2;
      n_cmp++; if (hi !== 32'd0 || lo !== 32'd47) begin n_bad++; $display("FAIL flush_vs_commit: got %0h/%0h want 0/2f", hi, lo); end
      n_cmp++; if (du_div !== 1'b0) begin n_bad++; $display("FAIL flush_vs_commit_cmd: got %b want 0", du_div); end
   endtask

   task automatic test_timeout(input logic with_strobe);
      int early;
      tick(); present(3'd0, 1'b0, 32'd3, 32'd4);
      tick(); op_valid = 1'b0;
      early = 0;
      for (int i = 1; i < TO; i++) begin
         #2;
         if (err !== 1'b0 || du_clear !== 1'b0) early++;
         tick();
      end
      n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL timeout_early: got %0d early cycles want 0", early); end
      if (with_strobe) begin
         du_write_hi_lo = 1'b1; du_hi_out = 32'h000000AB; du_lo_out = 32'h000000CD;
         #2;
         n_cmp++; if (err !== 1'b0 || du_clear !== 1'b0) begin n_bad++; $display("FAIL timeout_strobe_err: got err=%b clear=%b want 0/0", err, du_clear); end
         tick(); du_write_hi_lo = 1'b0; #2;
         n_cmp++; if (hi !== 32'hAB || lo !== 32'hCD) begin n_bad++; $display("FAIL timeout_strobe_commit: got %0h/%0h want ab/cd", hi, lo); end
      end else begin
         #2;
         n_cmp++; if (err !== 1'b1 || du_clear !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got err=%b clear=%b want 1/1", err, du_clear); end
         tick();
         present(3'd7, 1'b0, 32'd0, 32'd0);
         n_cmp++; if (err !== 1'b0 || du_mul !== 1'b0) begin n_bad++; $display("FAIL timeout_after: got err=%b mul=%b want 0/0", err, du_mul); end
         n_cmp++; if (stall !== 1'b0 || rd_valid !== 1'b1 || rd_val !== 32'd47) begin n_bad++; $display("FAIL timeout_idle_mflo: got stall=%b valid=%b val=%0d want 0/1/47", stall, rd_valid, rd_val); end
         op_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid_busy();
      tick(); present(3'd3, 1'b1, 32'd5, 32'd5);
      tick(); op_valid = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick(); reset = 1'b0; #2;
      n_cmp++; if ({du_mul, du_sub, du_sign} !== 3'b000 || du_a !== 32'd0 || hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL reset_mid_busy: got cmd=%b a=%0h hi=%0h lo=%0h want 000/0/0/0", {du_mul, du_sub, du_sign}, du_a, hi, lo); end
   endtask

   initial begin
      test_reset();
      test_mult_mflo();
      test_mthi_mfhi();
      test_madd();
      test_flush();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_reset_mid_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hi_lo_ctrl.md
Name: hi_lo_ctrl

Overview:
- Issue/commit controller and architectural HI/LO register pair for the multi-cycle multiply/divide unit.
- Sits in the execute stage and accepts MULT/DIV/MADD/MSUB/MTHI/MTLO/MFHI/MFLO requests.
- Drives the div/mul unit's command inputs, holding them stable for the whole computation, and commits its result to HI/LO on the write strobe.
- Interlocks the pipeline when a HI/LO instruction arrives while a computation is in flight; also handles flush and a watchdog timeout.

Parameters:
- N, 32, data width of operands and of HI/LO.
- TIMEOUT, 64, maximum BUSY cycles before abort. Must be greater than N+8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; kills any in-flight operation.
- op_valid  in  1  a HI/LO instruction is presented this cycle.
- op  in  3  operation code: 0 MULT, 1 DIV, 2 MADD, 3 MSUB, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- op_sign  in  1  signed operation (MULT/DIV/MADD/MSUB only).
- rs_val  in  N  first operand; also the source value for MTHI/MTLO.
- rt_val  in  N  second operand.
- stall  out  1  pipeline must hold the presented instruction.
- rd_val  out  N  MFHI/MFLO result.
- rd_valid  out  1  rd_val is valid this cycle.
- err  out  1  one-cycle pulse on watchdog timeout.
- hi  out  N  architectural HI register.
- lo  out  N  architectural LO register.
- du_mul, du_div, du_add, du_sub, du_sign  out  1 each  registered command bits to the unit.
- du_a, du_b  out  N  registered operands to the unit.
- du_hi_in, du_lo_in  out  N  accumulator inputs to the unit.
- du_clear  out  1  abort pulse to the unit.
- du_hold_result  out  1  result-hold request to the unit.
- du_hi_out, du_lo_out  in  N  result from the unit.
- du_write_hi_lo  in  1  unit result valid strobe.
- du_waiting_result  in  1  unit busy indication.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values:
  - State IDLE; hi=lo=0.
  - All du_* command bits, du_a and du_b = 0.
  - stall=0, rd_valid=0, err=0; timeout counter = 0.
- States: IDLE, BUSY.
- IDLE, with op_valid and no flush:
  - op 0-3 is accepted this cycle (stall=0).
  - At the edge: du_a<=rs_val, du_b<=rt_val, du_sign<=op_sign, du_mul<=(op is 0, 2 or 3), du_div<=(op==1), du_add<=(op==2), du_sub<=(op==3). Counter <= 0; state -> BUSY.
  - MTHI: hi<=rs_val at the edge. MTLO: lo<=rs_val at the edge. No state change.
  - MFHI/MFLO: combinationally rd_valid=1, rd_val=hi or lo (current register value). No state change.
- BUSY:
  - stall = op_valid; non-HI/LO instructions are not stalled.
  - du_a, du_b, command bits, du_hi_in and du_lo_in stay constant.
  - Counter increments by 1 per cycle.
- Commit:
  - du_write_hi_lo=1 in BUSY without flush: at the edge, hi<=du_hi_out, lo<=du_lo_out, all command bits <=0, state -> IDLE.
  - In the following cycle the unit returns to its idle state, sees mul=div=0 and stays there.
  - A stalled MFHI/MFLO is accepted in that cycle and reads the committed value.
- du_hi_in = hi, du_lo_in = lo at all times. These are stable during BUSY because MTHI/MTLO are stalled.
- du_hold_result = 0 always.
- du_clear = flush | timeout abort (combinational, same cycle).
- Flush:
  - flush=1 in any state: no request is accepted and rd_valid=0.
  - State -> IDLE; command bits <= 0; hi/lo unchanged.
  - Flush coincident with du_write_hi_lo: flush wins and the result is discarded.
- Timeout:
  - In BUSY with counter == TIMEOUT-1 and no du_write_hi_lo: err=1 and du_clear=1 this cycle.
  - At the edge: state -> IDLE, command bits <= 0, hi/lo unchanged.
  - du_write_hi_lo in the same cycle wins over the timeout: normal commit, no err.
- du_waiting_result is informational only; the commit decision uses du_write_hi_lo only.
- Reset mid-BUSY: everything returns to reset values at the edge. The unit is reset by the same reset.

Test Plan:
- Reset -> hi=lo=0, stall=0, rd_valid=0, err=0, du_mul=du_div=0, du_a=du_b=0.
- MULT unsigned, rs=7, rt=6; unit model strobes du_write_hi_lo with hi_out=0, lo_out=42 after 33 cycles; MFLO presented back-to-back -> du_mul=1, du_a=7, du_b=6 from the next cycle; stall=1 for MFLO until commit; hi=0, lo=42 at the commit edge; then rd_val=42, rd_valid=1; du_mul=0.
- MTHI rs=0xDEAD then MFHI next cycle -> no stall, rd_val=0x0000DEAD.
- MADD signed with hi=0, lo=5 -> du_mul=du_add=du_sign=1, du_lo_in=5, du_hi_in=0 held for all BUSY cycles; commit of hi_out=0, lo_out=47 -> lo=47.
- DIV in flight, flush at BUSY cycle 10 -> du_clear=1 for one cycle, IDLE next cycle, hi/lo unchanged; repeat with flush coinciding with du_write_hi_lo -> hi/lo unchanged.
- Unit model never strobes -> err=1 and du_clear=1 exactly TIMEOUT cycles after acceptance, IDLE next cycle; strobe on that same cycle -> commit, err=0.
